// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline: data-memory stalls, redirects, load-use, fetch stalls, traps.
// Control outputs are combinational from the current state and inputs; state, pending trap and stall counter are registered.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        trap_req,
  output logic        pc_halt,
  output logic        if_id_halt,
  output logic        if_id_flush,
  output logic        id_ex_halt,
  output logic        id_ex_flush,
  output logic        ex_mem_halt,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        pc_sel_trap,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        trap_pend_q, trap_pend_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic dstall;
  logic load_use;

  always_comb begin
    dstall   = (state_q != TRAP) && dmem_req && !dmem_ready;
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Only one cause drives the outputs in a cycle, so a register never sees hold and clear together.
  always_comb begin
    pc_halt      = 1'b0;
    if_id_halt   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_halt   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_halt  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_sel_trap  = 1'b0;
    if (rst) begin
      if (state_q == TRAP) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        mem_wb_flush = 1'b1;
        pc_sel_trap  = 1'b1;
      end else if (dstall) begin
        pc_halt      = 1'b1;
        if_id_halt   = 1'b1;
        id_ex_halt   = 1'b1;
        ex_mem_halt  = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (load_use) begin
        pc_halt      = 1'b1;
        if_id_halt   = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (!imem_ready) begin
        pc_halt      = 1'b1;
        if_id_flush  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    trap_pend_d = trap_pend_q;
    case (state_q)
      RUN: begin
        if (dstall) begin
          state_d     = DWAIT;
          trap_pend_d = trap_req;
        end else if (trap_req) begin
          state_d = TRAP;
        end
      end
      DWAIT: begin
        if (trap_req) trap_pend_d = 1'b1;
        // A trap raised while memory was busy is taken on the completing edge.
        if (dmem_ready) begin
          if (trap_pend_q || trap_req) begin
            state_d     = TRAP;
            trap_pend_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      TRAP: begin
        state_d     = RUN;
        trap_pend_d = 1'b0;
      end
      default: begin
        state_d     = RUN;
        trap_pend_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_halt && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      trap_pend_q <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      trap_pend_q <= trap_pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
